// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: rebuilds LSB-first frames into WIDTH-bit
// words, holds each word in an output register drained by valid/ready, and
// reports framing errors and overruns as sticky flags.
module sipo_frame_receiver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    input  logic                          frame_start,
    input  logic                          out_ready,
    input  logic                          clear_flags,
    output logic [WIDTH-1:0]              parallel_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic [$clog2(WIDTH+0)+1-1:0]  bit_count,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;
    logic               complete;
    logic [WIDTH-1:0]   word;

    // Next-state, datapath and output-register update
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q & ~clear_flags;
        ferr_d   = ferr_q & ~clear_flags;
        complete = 1'b0;
        word     = {serial_in, shift_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    shift_d = word;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = word;
                if (frame_start) begin
                    // Abort beats completion: restart with this bit as bit 0
                    ferr_d = 1'b1;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A slot is free if empty or being drained this same cycle
        if (complete) begin
            if (!valid_q || out_ready) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == SHIFT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign bit_count    = cnt_q;
    assign overrun      = ovr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver with WIDTH=8.
module tb_sipo_frame_receiver;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             serial_in;
    logic             frame_start;
    logic             out_ready;
    logic             clear_flags;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
    logic             frame_err;

    int checks   = 0;
    int failures = 0;

    sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .clear_flags  (clear_flags),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .bit_count    (bit_count),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive bits first..last of w, LSB first; frame_start on bit 0
    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            serial_in   = w[i];
            frame_start = (i == 0);
            tick(1);
        end
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        serial_in   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        tick(2);

        // Reset state
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pout", 32'(parallel_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(bit_count), 32'h0);
        check("rst_flags", {30'h0, overrun, frame_err}, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Basic receive with ready held high
        out_ready = 1'b1;
        send_bits(8'hA5, 0, 0);
        check("basic_cnt1", 32'(bit_count), 32'h1);
        check("basic_busy", 32'(busy), 32'h1);
        send_bits(8'hA5, 1, 7);
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_pout", 32'(parallel_out), 32'hA5);
        check("basic_idle_cnt", 32'(bit_count), 32'h0);
        check("basic_idle_busy", 32'(busy), 32'h0);
        tick(1);
        check("basic_drained", 32'(out_valid), 32'h0);
        check("basic_flags", {30'h0, overrun, frame_err}, 32'h0);

        // Backpressure: second back-to-back word is dropped
        out_ready = 1'b0;
        send_bits(8'hA5, 0, 7);
        send_bits(8'h3C, 0, 7);
        check("ovr_valid", 32'(out_valid), 32'h1);
        check("ovr_pout", 32'(parallel_out), 32'hA5);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_no_ferr", 32'(frame_err), 32'h0);
        out_ready = 1'b1;
        tick(1);
        check("ovr_drain", 32'(out_valid), 32'h0);
        out_ready   = 1'b0;
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Simultaneous drain and load
        send_bits(8'hA5, 0, 7);
        check("sim_first", 32'(parallel_out), 32'hA5);
        send_bits(8'h3C, 0, 6);
        out_ready = 1'b1;
        send_bits(8'h3C, 7, 7);
        check("sim_pout", 32'(parallel_out), 32'h3C);
        check("sim_valid", 32'(out_valid), 32'h1);
        check("sim_no_ovr", 32'(overrun), 32'h0);
        tick(1);
        check("sim_drain", 32'(out_valid), 32'h0);

        // Mid-frame abort after 4 bits
        send_bits(8'hFF, 0, 3);
        check("abort4_cnt", 32'(bit_count), 32'h4);
        check("abort4_no_ferr", 32'(frame_err), 32'h0);
        send_bits(8'h81, 0, 0);
        check("abort4_ferr", 32'(frame_err), 32'h1);
        check("abort4_restart", 32'(bit_count), 32'h1);
        check("abort4_busy", 32'(busy), 32'h1);
        check("abort4_no_word", 32'(out_valid), 32'h0);
        send_bits(8'h81, 1, 7);
        check("abort4_valid", 32'(out_valid), 32'h1);
        check("abort4_pout", 32'(parallel_out), 32'h81);
        tick(1);
        check("abort4_drain", 32'(out_valid), 32'h0);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("abort_clear", 32'(frame_err), 32'h0);

        // Abort exactly on the last bit: abort beats completion
        send_bits(8'hFF, 0, 6);
        check("abort7_cnt", 32'(bit_count), 32'h7);
        send_bits(8'h81, 0, 0);
        check("abort7_ferr", 32'(frame_err), 32'h1);
        check("abort7_restart", 32'(bit_count), 32'h1);
        check("abort7_no_word", 32'(out_valid), 32'h0);
        send_bits(8'h81, 1, 7);
        check("abort7_pout", 32'(parallel_out), 32'h81);
        check("abort7_valid", 32'(out_valid), 32'h1);
        tick(1);

        // Asynchronous reset mid-frame with a pending word
        out_ready = 1'b0;
        send_bits(8'hA5, 0, 7);
        send_bits(8'hFF, 0, 4);
        check("mrst_pre_cnt", 32'(bit_count), 32'h5);
        check("mrst_pre_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_pout", 32'(parallel_out), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_cnt", 32'(bit_count), 32'h0);
        check("mrst_flags", {30'h0, overrun, frame_err}, 32'h0);
        #3;
        rst_n = 1'b1;
        tick(1);
        out_ready = 1'b1;
        send_bits(8'h5A, 0, 7);
        check("mrst_rx_pout", 32'(parallel_out), 32'h5A);
        check("mrst_rx_valid", 32'(out_valid), 32'h1);
        tick(1);

        // Overrun set in the same cycle as clear_flags: set wins
        out_ready = 1'b0;
        send_bits(8'hA5, 0, 7);
        send_bits(8'h3C, 0, 6);
        check("prio_pre", 32'(overrun), 32'h0);
        clear_flags = 1'b1;
        send_bits(8'h3C, 7, 7);
        clear_flags = 1'b0;
        check("prio_set_wins", 32'(overrun), 32'h1);
        check("prio_pout", 32'(parallel_out), 32'hA5);
        out_ready = 1'b1;
        tick(1);

        // Idle with serial_in toggling and no frame_start
        for (int i = 0; i < 6; i++) begin
            serial_in = i[0];
            tick(1);
        end
        serial_in = 1'b0;
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_cnt", 32'(bit_count), 32'h0);
        check("idle_ovr_sticky", 32'(overrun), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
